lc3b_mult_div: RTL and testbench

Iterative signed 16-bit multiply/divide unit for the execute stage of the LC-3b pipeline. It is the consumer of the `mult_div` control bit and `alu_mult_div` ALU op carried in `lc3b_control`. The execute stage launches one operation with `start` and holds the pipeline while the unit works. The unit returns a 32-bit product, or a quotient and remainder, after a fixed number of cycles.

---
 rtl/lc3b_mult_div_pkg.sv | 16 +
 rtl/lc3b_mult_div.sv | 164 ++++++++++++++++
 tb/tb_lc3b_mult_div.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/lc3b_mult_div_pkg.sv
// Shared LC-3b types used by the execute-stage multiply/divide unit.
// Provides the machine word type, the unit's state encoding and the iteration count.
package lc3b_mult_div_pkg;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        md_idle,
        md_calc,
        md_fix,
        md_done
    } lc3b_md_state;

    localparam int MD_ITERS = 16;

endpackage

// File: rtl/lc3b_mult_div.sv
// Iterative signed 16-bit multiply / divide unit for the LC-3b execute stage.
// Ports: clk, reset (sync, active-high), start/div/a/b launch, flush abort,
//        busy, done (1-cycle pulse), result (lo/quotient), result_hi (hi/remainder).
module lc3b_mult_div
    import lc3b_mult_div_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     start,
    input  logic     div,
    input  lc3b_word a,
    input  lc3b_word b,
    input  logic     flush,
    output logic     busy,
    output logic     done,
    output lc3b_word result,
    output lc3b_word result_hi
);

    localparam logic [4:0] LAST_ITER = 5'(MD_ITERS - 1);

    // Magnitude needs 17 bits so that |16'h8000| is representable.
    function automatic logic [16:0] abs17(input lc3b_word x);
        logic [16:0] sx;
        sx = {x[15], x};
        return x[15] ? (17'd0 - sx) : sx;
    endfunction

    function automatic logic [31:0] cond_neg32(input logic [31:0] x,
                                               input logic n);
        return n ? (32'd0 - x) : x;
    endfunction

    function automatic lc3b_word cond_neg16(input lc3b_word x,
                                            input logic n);
        return n ? (16'd0 - x) : x;
    endfunction

    lc3b_md_state state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    // Multiply: shifting multiplicand. Divide: dividend in [15:0], quotient
    // bits shifted in from the bottom as the dividend shifts out the top.
    logic [31:0]  a_q, a_d;
    // Multiplier magnitude (shifts right) or divisor magnitude (static).
    logic [16:0]  b_q, b_d;
    // Multiply: product accumulator. Divide: partial remainder in [16:0].
    logic [31:0]  acc_q, acc_d;
    logic         neg_q, neg_d;
    logic         sa_q, sa_d;
    logic         div_q, div_d;
    lc3b_word     result_q, result_d;
    lc3b_word     result_hi_q, result_hi_d;

    logic [16:0]  rem_sh;
    logic [17:0]  diff;
    logic         ge;
    logic [31:0]  prod;

    // Restoring-division step: shift in the next dividend bit, trial subtract.
    assign rem_sh = {acc_q[15:0], a_q[15]};
    assign diff   = {1'b0, rem_sh} - {1'b0, b_q};
    assign ge     = ~diff[17];
    assign prod   = cond_neg32(acc_q, neg_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        neg_d       = neg_q;
        sa_d        = sa_q;
        div_d       = div_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;

        unique case (state_q)
            md_idle: begin
                if (start) begin
                    if (div && (b == 16'h0000)) begin
                        result_d    = 16'hFFFF;
                        result_hi_d = a;
                        state_d     = md_done;
                    end else begin
                        a_d     = {15'd0, abs17(a)};
                        b_d     = abs17(b);
                        acc_d   = 32'd0;
                        cnt_d   = 5'd0;
                        neg_d   = a[15] ^ b[15];
                        sa_d    = a[15];
                        div_d   = div;
                        state_d = md_calc;
                    end
                end
            end
            md_calc: begin
                if (div_q) begin
                    acc_d = {15'd0, ge ? diff[16:0] : rem_sh};
                    a_d   = {16'd0, a_q[14:0], ge};
                end else begin
                    acc_d = acc_q + (b_q[0] ? a_q : 32'd0);
                    a_d   = {a_q[30:0], 1'b0};
                    b_d   = {1'b0, b_q[16:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = md_fix;
                end
            end
            md_fix: begin
                if (div_q) begin
                    result_d    = cond_neg16(a_q[15:0], neg_q);
                    result_hi_d = cond_neg16(acc_q[15:0], sa_q);
                end else begin
                    result_d    = prod[15:0];
                    result_hi_d = prod[31:16];
                end
                state_d = md_done;
            end
            md_done: begin
                state_d = md_idle;
            end
        endcase

        // Abort wins over everything, including a same-cycle start.
        if (flush) begin
            state_d     = md_idle;
            result_d    = result_q;
            result_hi_d = result_hi_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= md_idle;
            cnt_q       <= 5'd0;
            a_q         <= 32'd0;
            b_q         <= 17'd0;
            acc_q       <= 32'd0;
            neg_q       <= 1'b0;
            sa_q        <= 1'b0;
            div_q       <= 1'b0;
            result_q    <= 16'h0000;
            result_hi_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            neg_q       <= neg_d;
            sa_q        <= sa_d;
            div_q       <= div_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
        end
    end

    assign busy      = (state_q != md_idle);
    assign done      = (state_q == md_done);
    assign result    = result_q;
    assign result_hi = result_hi_q;

endmodule

// File: tb/tb_lc3b_mult_div.sv
// Directed self-checking bench for lc3b_mult_div.
// Drives and samples on the falling edge; expected values are hand-computed.
module tb_lc3b_mult_div;

    logic        clk;
    logic        reset;
    logic        start;
    logic        div;
    logic [15:0] a;
    logic [15:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [15:0] result_hi;

    int checks = 0;
    int errors = 0;

    lc3b_mult_div dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .div       (div),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch at E0, count the 16 CALC edges, expect done only between E17/E18.
    task automatic run_op(input string tag, input logic d,
                          input logic [15:0] av, input logic [15:0] bv,
                          input logic [15:0] elo, input logic [15:0] ehi,
                          input bit extra);
        int early;
        early = 0;
        @(negedge clk);
        start = 1'b1; div = d; a = av; b = bv;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = 16'h0000; b = 16'h0000;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        for (int i = 1; i <= 16; i++) begin
            if (extra && i == 5) begin
                start = 1'b1; div = ~d; a = 16'h1234; b = 16'h0003;
            end
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (done) early++;
        end
        chk({tag, "_early_done"}, 32'(early), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_lo"}, {16'd0, result}, {16'd0, elo});
        chk({tag, "_hi"}, {16'd0, result_hi}, {16'd0, ehi});
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_done_end"}, {31'd0, done}, 32'd0);
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    // Multiply 7*3 aborted at E8 by flush or reset.
    task automatic abort_op(input string tag, input bit use_reset,
                            input logic [15:0] elo, input logic [15:0] ehi);
        int seen;
        seen = 0;
        @(negedge clk);
        start = 1'b1; div = 1'b0; a = 16'h0007; b = 16'h0003;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        if (use_reset) reset = 1'b1;
        else flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; flush = 1'b0;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_lo"}, {16'd0, result}, {16'd0, elo});
        chk({tag, "_hi"}, {16'd0, result_hi}, {16'd0, ehi});
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk({tag, "_no_done"}, 32'(seen), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; div = 1'b0;
        a = 16'h0000; b = 16'h0000; flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_lo", {16'd0, result}, 32'd0);
        chk("rst_hi", {16'd0, result_hi}, 32'd0);

        run_op("mul_7_m3", 1'b0, 16'h0007, 16'hFFFD,
               16'hFFEB, 16'hFFFF, 1'b0);
        run_op("mul_min_min", 1'b0, 16'h8000, 16'h8000,
               16'h0000, 16'h4000, 1'b0);
        run_op("div_m7_2", 1'b1, 16'hFFF9, 16'h0002,
               16'hFFFD, 16'hFFFF, 1'b1);
        run_op("div_min_m1", 1'b1, 16'h8000, 16'hFFFF,
               16'h8000, 16'h0000, 1'b0);
        run_op("div_100_7", 1'b1, 16'h0064, 16'h0007,
               16'h000E, 16'h0002, 1'b0);
        run_op("div_7_m2", 1'b1, 16'h0007, 16'hFFFE,
               16'hFFFD, 16'h0001, 1'b0);

        // Divide by zero shortcut: done right after E0.
        @(negedge clk);
        start = 1'b1; div = 1'b1; a = 16'h0005; b = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("dz_done", {31'd0, done}, 32'd1);
        chk("dz_busy", {31'd0, busy}, 32'd1);
        chk("dz_lo", {16'd0, result}, 32'h0000_FFFF);
        chk("dz_hi", {16'd0, result_hi}, 32'h0000_0005);
        @(posedge clk);
        @(negedge clk);
        chk("dz_done_end", {31'd0, done}, 32'd0);
        chk("dz_busy_end", {31'd0, busy}, 32'd0);

        abort_op("flush_e8", 1'b0, 16'hFFFF, 16'h0005);

        // flush and start together: start must be dropped.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; div = 1'b1;
        a = 16'h0009; b = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", {31'd0, busy}, 32'd0);
        chk("flush_start_done", {31'd0, done}, 32'd0);
        chk("flush_start_hi", {16'd0, result_hi}, 32'h0000_0005);

        abort_op("reset_e8", 1'b1, 16'h0000, 16'h0000);

        run_op("mul_after_rst", 1'b0, 16'h0100, 16'h0100,
               16'h0000, 16'h0001, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
